id_ex_stage: RTL and testbench

- Pipeline register between decode and the execute-stage ALU.
- Accepts one decoded instruction per cycle over a valid/ready handshake. Holds the register operands and refreshes them with forwarded results from the MEM and WB stages.
- Detects load-use hazards and drives ALU operand A, operand B and the 12-bit one-hot ALU opcode to the ALU, plus the side-band fields the MEM stage needs.

---
 rtl/id_ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : Decode-to-execute pipeline register. Holds one decoded
//            instruction, keeps its register operands fresh from the MEM/WB
//            forwarding paths, stalls on load-use hazards and drives the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    // decode side
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [4:0]            id_sa,
    input  logic [1:0]            id_a_sel,
    input  logic                  id_b_sel,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_we,
    input  logic                  id_mem_rd,
    input  logic                  id_mem_wr,
    // forwarding paths
    input  logic                  mem_fwd_we,
    input  logic [REG_ADDR_W-1:0] mem_fwd_dst,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data,
    input  logic                  mem_fwd_pending,
    input  logic                  wb_fwd_we,
    input  logic [REG_ADDR_W-1:0] wb_fwd_dst,
    input  logic [DATA_WIDTH-1:0] wb_fwd_data,
    input  logic                  flush,
    // execute side
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  ex_reg_we,
    output logic                  ex_mem_rd,
    output logic                  ex_mem_wr
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, rs_data_q, rt_data_q, imm_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, dst_q;
    logic [4:0]            sa_q;
    logic [1:0]            a_sel_q;
    logic                  b_sel_q;
    logic [ALU_OP_W-1:0]   op_q;
    logic                  reg_we_q, mem_rd_q, mem_wr_q;

    logic                  w_full, w_id_fire, w_ex_fire;
    logic                  w_haz_held, w_haz_in;
    logic [DATA_WIDTH-1:0] w_rs_cap, w_rt_cap, w_rs_ref, w_rt_ref;

    // Forward select: r0 is hard zero, then a settled MEM result, then WB,
    // otherwise the supplied current value.
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] r,
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_dst,
        input logic [DATA_WIDTH-1:0] m_data,
        input logic                  m_pend,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_dst,
        input logic [DATA_WIDTH-1:0] w_data
    );
        logic [DATA_WIDTH-1:0] res;
        if (r == '0)
            res = '0;
        else if (m_we && (m_dst == r) && !m_pend)
            res = m_data;
        else if (w_we && (w_dst == r))
            res = w_data;
        else
            res = cur;
        return res;
    endfunction

    // Handshake and hazard detection; rt always matters because it is store data.
    always_comb begin
        w_full     = (state_q != S_EMPTY);
        ex_valid   = (state_q == S_FULL);
        w_ex_fire  = ex_valid && ex_ready;
        id_ready   = !w_full || w_ex_fire;
        w_id_fire  = id_valid && id_ready;
        w_haz_held = w_full && mem_fwd_pending && mem_fwd_we && (mem_fwd_dst != '0) &&
                     (((a_sel_q == 2'd0) && (mem_fwd_dst == rs_q)) || (mem_fwd_dst == rt_q));
        w_haz_in   = mem_fwd_pending && mem_fwd_we && (mem_fwd_dst != '0) &&
                     (((id_a_sel == 2'd0) && (mem_fwd_dst == id_rs)) || (mem_fwd_dst == id_rt));
        w_rs_cap   = fwd_sel(id_rs, id_rs_data, mem_fwd_we, mem_fwd_dst, mem_fwd_data,
                             mem_fwd_pending, wb_fwd_we, wb_fwd_dst, wb_fwd_data);
        w_rt_cap   = fwd_sel(id_rt, id_rt_data, mem_fwd_we, mem_fwd_dst, mem_fwd_data,
                             mem_fwd_pending, wb_fwd_we, wb_fwd_dst, wb_fwd_data);
        w_rs_ref   = fwd_sel(rs_q, rs_data_q, mem_fwd_we, mem_fwd_dst, mem_fwd_data,
                             mem_fwd_pending, wb_fwd_we, wb_fwd_dst, wb_fwd_data);
        w_rt_ref   = fwd_sel(rt_q, rt_data_q, mem_fwd_we, mem_fwd_dst, mem_fwd_data,
                             mem_fwd_pending, wb_fwd_we, wb_fwd_dst, wb_fwd_data);
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (w_id_fire) state_d = w_haz_in ? S_STALL : S_FULL;
                S_FULL: begin
                    if (w_id_fire)      state_d = w_haz_in ? S_STALL : S_FULL;
                    else if (w_ex_fire) state_d = S_EMPTY;
                    else                state_d = w_haz_held ? S_STALL : S_FULL;
                end
                S_STALL: state_d = w_haz_held ? S_STALL : S_FULL;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // Payload: capture on accept (unless flushed), otherwise refresh held operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            sa_q      <= '0;
            a_sel_q   <= '0;
            b_sel_q   <= 1'b0;
            op_q      <= '0;
            dst_q     <= '0;
            reg_we_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
        end else if (w_id_fire && !flush) begin
            pc_q      <= id_pc;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rs_data_q <= w_rs_cap;
            rt_data_q <= w_rt_cap;
            imm_q     <= id_imm;
            sa_q      <= id_sa;
            a_sel_q   <= id_a_sel;
            b_sel_q   <= id_b_sel;
            op_q      <= id_alu_op;
            dst_q     <= id_dst;
            reg_we_q  <= id_reg_we;
            mem_rd_q  <= id_mem_rd;
            mem_wr_q  <= id_mem_wr;
        end else if (w_full && !w_id_fire) begin
            rs_data_q <= w_rs_ref;
            rt_data_q <= w_rt_ref;
        end
    end

    // Operand muxes from held state; the reserved A select drives zero.
    always_comb begin
        case (a_sel_q)
            2'd0:    alu_A = rs_data_q;
            2'd1:    alu_A = {{(DATA_WIDTH-5){1'b0}}, sa_q};
            2'd2:    alu_A = pc_q;
            default: alu_A = '0;
        endcase
        alu_B         = b_sel_q ? imm_q : rt_data_q;
        alu_op        = op_q;
        ex_pc         = pc_q;
        ex_store_data = rt_data_q;
        ex_dst        = dst_q;
        ex_reg_we     = reg_we_q;
        ex_mem_rd     = mem_rd_q;
        ex_mem_wr     = mem_wr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed self-checking bench for id_ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_sa, id_dst;
    logic [1:0]  id_a_sel;
    logic        id_b_sel;
    logic [11:0] id_alu_op;
    logic        id_reg_we, id_mem_rd, id_mem_wr;
    logic        mem_fwd_we, mem_fwd_pending, wb_fwd_we, flush;
    logic [4:0]  mem_fwd_dst, wb_fwd_dst;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid, ex_ready;
    logic [31:0] alu_A, alu_B, ex_pc, ex_store_data;
    logic [11:0] alu_op;
    logic [4:0]  ex_dst;
    logic        ex_reg_we, ex_mem_rd, ex_mem_wr;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_sa(id_sa), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_alu_op(id_alu_op), .id_dst(id_dst), .id_reg_we(id_reg_we),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_dst(mem_fwd_dst), .mem_fwd_data(mem_fwd_data),
        .mem_fwd_pending(mem_fwd_pending),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_dst(wb_fwd_dst), .wb_fwd_data(wb_fwd_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_A(alu_A), .alu_B(alu_B),
        .alu_op(alu_op), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; checks happen 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_rs_data = 0;
        id_rt_data = 0; id_imm = 0; id_sa = 0; id_a_sel = 0; id_b_sel = 0; id_alu_op = 0;
        id_dst = 0; id_reg_we = 0; id_mem_rd = 0; id_mem_wr = 0;
        mem_fwd_we = 0; mem_fwd_dst = 0; mem_fwd_data = 0; mem_fwd_pending = 0;
        wb_fwd_we = 0; wb_fwd_dst = 0; wb_fwd_data = 0; flush = 0; ex_ready = 1;

        // Reset
        tick(); tick();
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_id_ready", {31'b0, id_ready}, 32'd1);
        chk("rst_alu_A", alu_A, 32'd0);
        chk("rst_alu_op", {20'b0, alu_op}, 32'd0);
        chk("rst_ex_ctl", {29'b0, ex_reg_we, ex_mem_rd, ex_mem_wr}, 32'd0);
        rst = 1'b0;

        // Pass-through: addi r3,r1,5
        id_valid = 1; id_pc = 32'h100; id_rs = 1; id_rt = 0; id_rs_data = 10;
        id_rt_data = 32'h77; id_imm = 5; id_b_sel = 1; id_a_sel = 0; id_alu_op = 12'h001;
        id_dst = 3; id_reg_we = 1;
        tick();
        id_valid = 0;
        chk("pt_ex_valid", {31'b0, ex_valid}, 32'd1);
        chk("pt_alu_A", alu_A, 32'd10);
        chk("pt_alu_B", alu_B, 32'd5);
        chk("pt_alu_op", {20'b0, alu_op}, 32'h001);
        chk("pt_ex_dst", {27'b0, ex_dst}, 32'd3);
        chk("pt_ex_pc", ex_pc, 32'h100);
        chk("pt_store_r0", ex_store_data, 32'd0);
        tick();
        chk("pt_drain", {31'b0, ex_valid}, 32'd0);

        // Forward priority: MEM beats WB
        id_valid = 1; id_rs = 4; id_rs_data = 32'h11; id_rt = 5; id_rt_data = 32'h22;
        id_a_sel = 0; id_b_sel = 0; id_alu_op = 12'h002; id_dst = 6;
        mem_fwd_we = 1; mem_fwd_dst = 4; mem_fwd_data = 32'hAA;
        wb_fwd_we = 1; wb_fwd_dst = 4; wb_fwd_data = 32'hBB;
        tick();
        chk("fw_mem_A", alu_A, 32'hAA);
        chk("fw_B_nomatch", alu_B, 32'h22);
        // r0 always reads zero; issued back to back
        id_rs = 0; id_rs_data = 32'h55; mem_fwd_dst = 0; wb_fwd_dst = 0;
        tick();
        chk("fw_r0_valid", {31'b0, ex_valid}, 32'd1);
        chk("fw_r0_A", alu_A, 32'd0);
        // WB only when MEM targets another register
        id_rs = 7; id_rs_data = 32'h33; id_b_sel = 1; id_imm = 32'h40;
        mem_fwd_dst = 9; wb_fwd_dst = 7;
        tick();
        chk("fw_wb_A", alu_A, 32'hBB);
        chk("fw_wb_B", alu_B, 32'h40);
        id_valid = 0; mem_fwd_we = 0; wb_fwd_we = 0;
        tick();
        chk("fw_drain", {31'b0, ex_valid}, 32'd0);

        // Load-use stall: pending for 3 cycles
        id_valid = 1; id_rs = 2; id_rs_data = 32'h5; id_rt = 0; id_a_sel = 0; id_b_sel = 1;
        id_imm = 1; id_alu_op = 12'h001; id_dst = 8;
        mem_fwd_we = 1; mem_fwd_dst = 2; mem_fwd_pending = 1; mem_fwd_data = 32'hDEAD;
        tick();
        id_valid = 0;
        chk("lu_stall1", {31'b0, ex_valid}, 32'd0);
        chk("lu_id_ready", {31'b0, id_ready}, 32'd0);
        tick();
        chk("lu_stall2", {31'b0, ex_valid}, 32'd0);
        tick();
        chk("lu_stall3", {31'b0, ex_valid}, 32'd0);
        mem_fwd_pending = 0; mem_fwd_data = 32'h1234;
        tick();
        chk("lu_release", {31'b0, ex_valid}, 32'd1);
        chk("lu_alu_A", alu_A, 32'h1234);
        mem_fwd_we = 0;
        tick();
        chk("lu_drain", {31'b0, ex_valid}, 32'd0);

        // Backpressure
        ex_ready = 0; id_valid = 1; id_pc = 32'h200; id_a_sel = 1; id_sa = 7; id_rs = 1;
        id_rs_data = 9; id_b_sel = 0; id_rt = 3; id_rt_data = 32'h99; id_alu_op = 12'h800;
        id_dst = 10; id_mem_wr = 1;
        tick();
        chk("bp_alu_A_sa", alu_A, 32'd7);
        chk("bp_store", ex_store_data, 32'h99);
        chk("bp_mem_wr", {31'b0, ex_mem_wr}, 32'd1);
        id_pc = 32'h300; id_a_sel = 2; id_dst = 11; id_alu_op = 12'h004; id_b_sel = 1;
        id_imm = 32'h10; id_mem_wr = 0;
        #1;
        chk("bp_id_ready0", {31'b0, id_ready}, 32'd0);
        tick();
        chk("bp_hold_pc", ex_pc, 32'h200);
        chk("bp_hold_dst", {27'b0, ex_dst}, 32'd10);
        chk("bp_hold_op", {20'b0, alu_op}, 32'h800);
        ex_ready = 1;
        #1;
        chk("bp_id_ready1", {31'b0, id_ready}, 32'd1);
        tick();
        chk("b2b_valid", {31'b0, ex_valid}, 32'd1);
        chk("b2b_alu_A_pc", alu_A, 32'h300);
        chk("b2b_alu_B", alu_B, 32'h10);
        chk("b2b_dst", {27'b0, ex_dst}, 32'd11);

        // Flush while full with an incoming instruction
        id_pc = 32'h400; id_dst = 12; flush = 1;
        #1;
        chk("fl_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("fl_ex_valid", {31'b0, ex_valid}, 32'd0);
        flush = 0; id_valid = 0;
        tick();
        chk("fl_never", {31'b0, ex_valid}, 32'd0);

        // Reserved A select, then reset mid-operation
        id_valid = 1; id_a_sel = 3; id_rs = 1; id_rs_data = 5; id_b_sel = 0; id_rt = 0;
        id_alu_op = 12'h010; id_dst = 13;
        tick();
        id_valid = 0;
        chk("asel3_A", alu_A, 32'd0);
        chk("asel3_valid", {31'b0, ex_valid}, 32'd1);
        rst = 1;
        tick();
        chk("mrst_valid", {31'b0, ex_valid}, 32'd0);
        chk("mrst_op", {20'b0, alu_op}, 32'd0);
        chk("mrst_dst", {27'b0, ex_dst}, 32'd0);
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
